// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Function : Debounces scanner key codes into press events and assembles a
//            packed-BCD decimal entry (A = start, B = clear, C = confirm).
// Revision : 1.0
// ============================================================================
module keypad_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3:0]                        key,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
  output logic                              active,
  output logic                              value_valid,
  output logic                              overflow,
  output logic                              key_event,
  output logic [3:0]                        event_code
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] c_deb_thr =
    DEB_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] c_max_digits = CNT_W'(NUM_DIGITS);

  localparam logic [3:0] c_key_start   = 4'hA;
  localparam logic [3:0] c_key_clear   = 4'hB;
  localparam logic [3:0] c_key_confirm = 4'hC;
  localparam logic [3:0] c_key_none    = 4'hD;
  localparam logic [3:0] c_key_unused  = 4'hF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [3:0]              r_cand;
  logic [DEB_W-1:0]        r_cnt;
  logic [3:0]              r_stable;
  logic [1:0]              r_state;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [CNT_W-1:0]        r_digit_cnt;
  logic                    r_overflow;
  logic                    r_value_valid;
  logic                    r_key_event;
  logic [3:0]              r_event_code;

  logic [3:0]              w_stable_next;
  logic                    w_event;
  logic                    w_is_digit;
  logic [4*NUM_DIGITS-1:0] w_digits_shift;

  // Stable value this edge would load; the Nth equal sample lands when the
  // counter already holds N-2 (first sample resets it to 0).
  always_comb begin
    w_stable_next = r_stable;
    if (key != r_cand) begin
      if (DEBOUNCE_CYCLES == 1) begin
        w_stable_next = key;
      end
    end else if ((DEBOUNCE_CYCLES == 1) || (r_cnt >= c_deb_thr)) begin
      w_stable_next = r_cand;
    end
  end

  // Only a release-to-press transition into a real command/digit is an event.
  assign w_event    = (r_stable == c_key_none) && (w_stable_next <= c_key_confirm);
  assign w_is_digit = (w_stable_next <= 4'h9);

  generate
    if (NUM_DIGITS == 1) begin : g_shift_single
      assign w_digits_shift = w_stable_next;
    end else begin : g_shift_multi
      assign w_digits_shift = {r_digits[4*NUM_DIGITS-5:0], w_stable_next};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand        <= c_key_unused;
      r_cnt         <= '0;
      r_stable      <= c_key_unused;
      r_state       <= S_IDLE;
      r_digits      <= '0;
      r_digit_cnt   <= '0;
      r_overflow    <= 1'b0;
      r_value_valid <= 1'b0;
      r_key_event   <= 1'b0;
      r_event_code  <= 4'h0;
    end else begin
      if (key != r_cand) begin
        r_cand <= key;
        r_cnt  <= '0;
      end else if (r_cnt != c_deb_max) begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
      r_stable      <= w_stable_next;
      r_key_event   <= w_event;
      r_value_valid <= 1'b0;

      if (w_event) begin
        r_event_code <= w_stable_next;
        case (r_state)
          S_IDLE: begin
            if (w_stable_next == c_key_start) begin
              r_state     <= S_ENTRY;
              r_digits    <= '0;
              r_digit_cnt <= '0;
              r_overflow  <= 1'b0;
            end
          end
          S_ENTRY: begin
            if (w_is_digit) begin
              if (r_digit_cnt < c_max_digits) begin
                r_digits    <= w_digits_shift;
                r_digit_cnt <= r_digit_cnt + CNT_W'(1);
              end else begin
                r_overflow <= 1'b1;
              end
            end else if ((w_stable_next == c_key_start) ||
                         (w_stable_next == c_key_clear)) begin
              r_digits    <= '0;
              r_digit_cnt <= '0;
              r_overflow  <= 1'b0;
            end else if (r_digit_cnt != '0) begin
              r_state       <= S_DONE;
              r_value_valid <= 1'b1;
            end
          end
          S_DONE: begin
            if (w_stable_next == c_key_start) begin
              r_state     <= S_ENTRY;
              r_digits    <= '0;
              r_digit_cnt <= '0;
              r_overflow  <= 1'b0;
            end else if (w_stable_next == c_key_clear) begin
              r_state     <= S_IDLE;
              r_digits    <= '0;
              r_digit_cnt <= '0;
              r_overflow  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign digits      = r_digits;
  assign digit_cnt   = r_digit_cnt;
  assign active      = (r_state == S_ENTRY);
  assign value_valid = r_value_valid;
  assign overflow    = r_overflow;
  assign key_event   = r_key_event;
  assign event_code  = r_event_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Function : Directed scoreboard bench for keypad_entry (N=4 digits, 4-sample
//            debounce); a monitor pops expected events as the DUT emits them.
// Revision : 1.0
// ============================================================================
module tb_keypad_entry;

  localparam int ND  = 4;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = 4'hD;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        active;
  logic        value_valid;
  logic        overflow;
  logic        key_event;
  logic [3:0]  event_code;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int vv_exp = 0;
  logic [3:0] evq[$];
  int         cycq[$];

  keypad_entry #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .digits     (digits),
    .digit_cnt  (digit_cnt),
    .active     (active),
    .value_valid(value_valid),
    .overflow   (overflow),
    .key_event  (key_event),
    .event_code (event_code)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; the key is first sampled at the next posedge,
  // so a valid event shows up DEB-1 edges after that one.
  task automatic press(input logic [3:0] code, input int hold, input int gap,
                       input bit exp_evt, input bit exp_vv);
    key = code;
    if (exp_evt) begin
      evq.push_back(code);
      cycq.push_back(cyc + DEB);
    end
    if (exp_vv) vv_exp++;
    repeat (hold) @(negedge clk);
    if (gap > 0) begin
      key = 4'hD;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic std_press(input logic [3:0] code, input bit exp_evt, input bit exp_vv);
    press(code, 10, 10, exp_evt, exp_vv);
  endtask

  initial begin
    fork
      begin : monitor
        logic prev_ke;
        logic prev_vv;
        prev_ke = 1'b0;
        prev_vv = 1'b0;
        forever begin
          @(negedge clk);
          if (key_event) begin
            check("key_event_single_cycle", {31'd0, prev_ke}, 32'd0);
            if (evq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_event: code 0x%0h at cycle %0d, none expected",
                       event_code, cyc);
            end else begin
              check("event_code", {28'd0, event_code}, {28'd0, evq.pop_front()});
              check("event_latency_cycle", cyc, cycq.pop_front());
            end
          end
          if (value_valid) begin
            check("value_valid_single_cycle", {31'd0, prev_vv}, 32'd0);
            if (vv_exp == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_value_valid: digits 0x%0h at cycle %0d, none expected",
                       digits, cyc);
            end else begin
              check("value_valid_digits_nonzero_cnt", {31'd0, digit_cnt != 3'd0}, 32'd1);
              vv_exp--;
            end
          end
          prev_ke = key_event;
          prev_vv = value_valid;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 0);
    check("rst_digit_cnt", digit_cnt, 0);
    check("rst_active", active, 0);
    check("rst_value_valid", value_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_key_event", key_event, 0);
    check("rst_event_code", event_code, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Nominal entry of 123
    std_press(4'hA, 1, 0);
    check("nom_active_after_A", active, 1);
    std_press(4'h1, 1, 0);
    std_press(4'h2, 1, 0);
    std_press(4'h3, 1, 0);
    check("nom_active_before_C", active, 1);
    std_press(4'hC, 1, 1);
    check("nom_digits", digits, 32'h0123);
    check("nom_digit_cnt", digit_cnt, 3);
    check("nom_active_done", active, 0);
    check("nom_overflow", overflow, 0);
    check("nom_event_code_held", event_code, 4'hC);

    // Bounce rejection inside a fresh entry
    std_press(4'hA, 1, 0);
    for (int i = 0; i < 5; i++) begin
      key = 4'h5;
      repeat (2) @(negedge clk);
      key = 4'hD;
      repeat (2) @(negedge clk);
    end
    key = 4'h5;
    repeat (3) @(negedge clk);
    key = 4'hD;
    repeat (10) @(negedge clk);
    check("bounce_digits", digits, 0);
    check("bounce_digit_cnt", digit_cnt, 0);

    // Overflow then clear
    for (int d = 1; d <= 5; d++) std_press(4'(d), 1, 0);
    check("ovf_digits", digits, 32'h1234);
    check("ovf_digit_cnt", digit_cnt, 4);
    check("ovf_flag", overflow, 1);
    std_press(4'hB, 1, 0);
    check("clr_digits", digits, 0);
    check("clr_digit_cnt", digit_cnt, 0);
    check("clr_overflow", overflow, 0);
    check("clr_active", active, 1);

    // Ignored inputs
    std_press(4'hC, 1, 0);
    check("empty_confirm_active", active, 1);
    press(4'h7, 10, 0, 1, 0);
    press(4'h8, 10, 10, 0, 0);
    check("direct_78_digits", digits, 32'h0007);
    check("direct_78_cnt", digit_cnt, 1);
    std_press(4'hF, 0, 0);
    check("unused_key_digits", digits, 32'h0007);
    std_press(4'hC, 1, 1);
    std_press(4'hB, 1, 0);
    check("to_idle_active", active, 0);
    std_press(4'h7, 1, 0);
    check("idle_digit_digits", digits, 0);
    check("idle_digit_cnt", digit_cnt, 0);
    check("idle_digit_active", active, 0);

    // DONE hold and exit
    std_press(4'hA, 1, 0);
    std_press(4'h4, 1, 0);
    std_press(4'h2, 1, 0);
    std_press(4'hC, 1, 1);
    check("done_digits", digits, 32'h0042);
    std_press(4'h6, 1, 0);
    std_press(4'hC, 1, 0);
    check("done_hold_digits", digits, 32'h0042);
    check("done_hold_cnt", digit_cnt, 2);
    check("done_hold_active", active, 0);
    std_press(4'hB, 1, 0);
    check("done_exit_B_digits", digits, 0);
    check("done_exit_B_active", active, 0);
    std_press(4'hA, 1, 0);
    check("reentry_active", active, 1);
    check("reentry_cnt", digit_cnt, 0);

    // Reset mid-entry with a key held through it
    std_press(4'h3, 1, 0);
    key = 4'h9;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("held_rst_digits", digits, 0);
    check("held_rst_cnt", digit_cnt, 0);
    check("held_rst_active", active, 0);
    key = 4'hD;
    repeat (10) @(negedge clk);
    std_press(4'hA, 1, 0);
    check("after_rst_active", active, 1);

    repeat (10) @(negedge clk);
    check("events_outstanding", evq.size(), 0);
    check("value_valid_outstanding", vv_exp, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
